cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) among `NUM_FU` functional units. Each FU hands over one completed result through a valid/ready handshake into a private one-entry holding buffer. Each cycle the arbiter grants one full buffer in round-robin order and drives it onto the CDB, which feeds the reorder buffer's `cdb_to_rob` / `rob_tag_from_cdb` / `wb_data_from_cdb` / `target_pc_from_cdb` / `mispredict_from_cdb` inputs and the reservation-station tag snoop. A flush from the ROB discards all buffered results.

---
 rtl/cdb_arbiter.sv | 151 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common-data-bus arbiter. Each functional unit hands one
//                completed result over a valid/ready handshake into its own
//                one-entry holding buffer. Every cycle the first full buffer
//                at or after the round-robin pointer is broadcast on the CDB.
//                A ROB flush discards every held result.
//  Ports       : clk            - clock, rising edge
//                reset          - asynchronous, active-low reset
//                flush          - ROB flush, drops all held results
//                fu_valid/ready - per-FU handshake
//                fu_rob_tag, fu_data, fu_target_pc, fu_mispredict
//                               - per-FU result fields (flattened, FU0 in LSBs)
//                cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc,
//                cdb_mispredict - broadcast towards the ROB / RS tag snoop
//                cdb_grant      - one-hot index of the broadcast buffer
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_FU      = 4,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU*ROB_TAG_LEN-1:0] fu_rob_tag,
    input  logic [NUM_FU*XLEN-1:0]        fu_data,
    input  logic [NUM_FU*XLEN-1:0]        fu_target_pc,
    input  logic [NUM_FU-1:0]             fu_mispredict,
    output logic [NUM_FU-1:0]             fu_ready,
    output logic                          cdb_valid,
    output logic [ROB_TAG_LEN-1:0]        cdb_rob_tag,
    output logic [XLEN-1:0]               cdb_data,
    output logic [XLEN-1:0]               cdb_target_pc,
    output logic                          cdb_mispredict,
    output logic [NUM_FU-1:0]             cdb_grant
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    // One extra bit so the wrap comparison can see values >= NUM_FU.
    localparam logic [PTR_W:0]   c_NUM_FU = (PTR_W+1)'(NUM_FU);
    localparam logic [PTR_W-1:0] c_LAST   = PTR_W'(NUM_FU - 1);

    // Holding buffers
    logic [NUM_FU-1:0]      full_q;
    logic [NUM_FU-1:0]      full_d;
    logic [ROB_TAG_LEN-1:0] tag_q  [NUM_FU];
    logic [XLEN-1:0]        data_q [NUM_FU];
    logic [XLEN-1:0]        tpc_q  [NUM_FU];
    logic [NUM_FU-1:0]      misp_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;

    // Selection
    logic                   w_found;
    logic [PTR_W-1:0]       w_sel;
    logic                   w_bus_valid;
    logic [NUM_FU-1:0]      w_grant;
    logic [NUM_FU-1:0]      w_accept;

    // ------------------------------------------------------------------------
    // Round-robin scan: first full buffer at rr_ptr, rr_ptr+1, ... (mod NUM_FU)
    // ------------------------------------------------------------------------
    always_comb begin
        logic [PTR_W:0] scan;
        scan    = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan >= c_NUM_FU) begin
                scan = scan - c_NUM_FU;
            end
            if (!w_found && full_q[scan[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = scan[PTR_W-1:0];
            end
        end
    end

    // A flush suppresses the broadcast entirely, grant included.
    assign w_bus_valid = w_found & ~flush;

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_grant[i] = w_bus_valid && (w_sel == PTR_W'(i));
        end
    end

    // A draining buffer is free again in the same cycle, so a granted FU can
    // hand over its next result back-to-back.
    assign fu_ready = ~{NUM_FU{flush}} & (~full_q | w_grant);
    assign w_accept = fu_valid & fu_ready;

    // ------------------------------------------------------------------------
    // CDB drive: fields are forced to zero whenever nothing is broadcast
    // ------------------------------------------------------------------------
    assign cdb_valid      = w_bus_valid;
    assign cdb_grant      = w_grant;
    assign cdb_rob_tag    = w_bus_valid ? tag_q[w_sel]  : '0;
    assign cdb_data       = w_bus_valid ? data_q[w_sel] : '0;
    assign cdb_target_pc  = w_bus_valid ? tpc_q[w_sel]  : '0;
    assign cdb_mispredict = w_bus_valid & misp_q[w_sel];

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        full_d   = full_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            full_d = '0;
        end else begin
            // Accept wins over drain for a buffer refilled in its grant cycle.
            full_d = (full_q & ~w_grant) | w_accept;
        end
        if (w_bus_valid) begin
            rr_ptr_d = (w_sel == c_LAST) ? '0 : w_sel + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q   <= '0;
            rr_ptr_q <= '0;
            misp_q   <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                tpc_q[i]  <= '0;
            end
        end else begin
            full_q   <= full_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_accept[i]) begin
                    tag_q[i]  <= fu_rob_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
                    data_q[i] <= fu_data[i*XLEN +: XLEN];
                    tpc_q[i]  <= fu_target_pc[i*XLEN +: XLEN];
                    misp_q[i] <= fu_mispredict[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. A queue-free array model
//                of the buffers and the rotating priority predicts every
//                output on each falling edge; directed scenarios add literal
//                expectations for key cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int TL = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [N-1:0]      fu_valid = '0;
    logic [N*TL-1:0]   fu_rob_tag = '0;
    logic [N*XL-1:0]   fu_data = '0;
    logic [N*XL-1:0]   fu_target_pc = '0;
    logic [N-1:0]      fu_mispredict = '0;
    logic [N-1:0]      fu_ready;
    logic              cdb_valid;
    logic [TL-1:0]     cdb_rob_tag;
    logic [XL-1:0]     cdb_data;
    logic [XL-1:0]     cdb_target_pc;
    logic              cdb_mispredict;
    logic [N-1:0]      cdb_grant;

    cdb_arbiter #(.NUM_FU(N), .XLEN(XL), .ROB_TAG_LEN(TL)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_rob_tag(fu_rob_tag), .fu_data(fu_data),
        .fu_target_pc(fu_target_pc), .fu_mispredict(fu_mispredict),
        .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag),
        .cdb_data(cdb_data), .cdb_target_pc(cdb_target_pc),
        .cdb_mispredict(cdb_mispredict), .cdb_grant(cdb_grant)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: each buffer is a slot {full, fields}; ptr is an integer.
    // ------------------------------------------------------------------------
    bit          m_full [N];
    logic [TL-1:0] m_tag [N];
    logic [XL-1:0] m_data[N];
    logic [XL-1:0] m_tpc [N];
    bit          m_misp [N];
    int          m_ptr = 0;

    int          e_sel;
    bit          e_valid;
    logic [N-1:0] e_grant, e_ready;
    logic [TL-1:0] e_tag;
    logic [XL-1:0] e_data, e_tpc;
    bit          e_misp;

    task automatic model_eval();
        e_sel = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (e_sel < 0 && m_full[j]) e_sel = j;
        end
        e_valid = (e_sel >= 0) && !flush;
        e_grant = '0;
        e_tag = '0; e_data = '0; e_tpc = '0; e_misp = 1'b0;
        if (e_valid) begin
            e_grant[e_sel] = 1'b1;
            e_tag  = m_tag[e_sel];
            e_data = m_data[e_sel];
            e_tpc  = m_tpc[e_sel];
            e_misp = m_misp[e_sel];
        end
        for (int i = 0; i < N; i++)
            e_ready[i] = !flush && (!m_full[i] || e_grant[i]);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_tpc[i] = '0; m_misp[i] = 0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_tpc[i] = '0; m_misp[i] = 0;
            end
            m_ptr = 0;
        end else begin
            model_eval();
            if (flush) begin
                for (int i = 0; i < N; i++) m_full[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (fu_valid[i] && e_ready[i]) begin
                        m_full[i] = 1;
                        m_tag[i]  = fu_rob_tag[i*TL +: TL];
                        m_data[i] = fu_data[i*XL +: XL];
                        m_tpc[i]  = fu_target_pc[i*XL +: XL];
                        m_misp[i] = fu_mispredict[i];
                    end else if (e_grant[i]) begin
                        m_full[i] = 0;
                    end
                end
            end
            if (e_valid) m_ptr = (e_sel + 1) % N;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        model_eval();
        chk("m_valid",  {63'b0, cdb_valid},      {63'b0, e_valid});
        chk("m_grant",  64'(cdb_grant),          64'(e_grant));
        chk("m_ready",  64'(fu_ready),           64'(e_ready));
        chk("m_tag",    64'(cdb_rob_tag),        64'(e_tag));
        chk("m_data",   64'(cdb_data),           64'(e_data));
        chk("m_tpc",    64'(cdb_target_pc),      64'(e_tpc));
        chk("m_misp",   {63'b0, cdb_mispredict}, {63'b0, e_misp});
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [TL-1:0] tag, input logic [XL-1:0] data,
                          input logic [XL-1:0] tpc, input logic misp);
        fu_rob_tag[i*TL +: TL]   = tag;
        fu_data[i*XL +: XL]      = data;
        fu_target_pc[i*XL +: XL] = tpc;
        fu_mispredict[i]         = misp;
    endtask

    logic [N-1:0] masks [12] = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b0110, 4'b1001,
                                 4'b1111, 4'b1111, 4'b0000, 4'b0011, 4'b0000, 4'b0000};

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", {63'b0, cdb_valid}, 64'd0);
        chk("rst_grant", 64'(cdb_grant), 64'd0);
        chk("rst_ready", 64'(fu_ready), 64'hF);
        step(); step();
        reset = 1'b1;
        step();

        // Single request from FU2
        set_fu(2, 5'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
        fu_valid = 4'b0100;
        step();
        fu_valid = '0;
        @(negedge clk); #1;
        chk("single_valid", {63'b0, cdb_valid}, 64'd1);
        chk("single_tag",   64'(cdb_rob_tag), 64'd7);
        chk("single_data",  64'(cdb_data), 64'hDEAD_BEEF);
        chk("single_grant", 64'(cdb_grant), 64'b0100);
        step();
        @(negedge clk); #1;
        chk("single_idle", {63'b0, cdb_valid}, 64'd0);
        chk("model_ptr3",  64'(m_ptr), 64'd3);

        // Pointer at 3: FU3 beats FU0
        set_fu(0, 5'd10, 32'h0000_000A, 32'h0, 1'b0);
        set_fu(3, 5'd13, 32'h0000_000D, 32'h0, 1'b0);
        fu_valid = 4'b1001;
        step();
        fu_valid = '0;
        @(negedge clk); #1;
        chk("ptr_first",  64'(cdb_grant), 64'b1000);
        step();
        @(negedge clk); #1;
        chk("ptr_second", 64'(cdb_grant), 64'b0001);
        chk("ptr_tag",    64'(cdb_rob_tag), 64'd10);
        step();

        // Mid-cycle reset while FU1 holds a result
        set_fu(1, 5'd9, 32'h0000_0099, 32'h0, 1'b0);
        fu_valid = 4'b0010;
        step();
        fu_valid = '0;
        #2;
        chk("pre_rst_valid", {63'b0, cdb_valid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {63'b0, cdb_valid}, 64'd0);
        chk("mid_rst_grant", 64'(cdb_grant), 64'd0);
        chk("mid_rst_ready", 64'(fu_ready), 64'hF);

        // Round robin: all FUs request continuously from reset release
        for (int i = 0; i < N; i++) set_fu(i, TL'(i + 1), 32'h11 * (i + 1), 32'h0, 1'b0);
        fu_valid = 4'b1111;
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("rr_grant", 64'(cdb_grant), 64'(4'b0001 << (c % 4)));
            chk("rr_ready", 64'(fu_ready),  64'(4'b0001 << (c % 4)));
            chk("rr_tag",   64'(cdb_rob_tag), 64'((c % 4) + 1));
            step();
        end
        fu_valid = '0;
        repeat (5) step();

        // Backpressure: pointer is 2, so FU0 wins and FU1 waits
        set_fu(0, 5'd20, 32'h0000_0020, 32'h0, 1'b0);
        set_fu(1, 5'd21, 32'h1111_0001, 32'h0, 1'b0);
        fu_valid = 4'b0011;
        step();
        fu_valid = 4'b0010;
        set_fu(1, 5'd22, 32'h2222_0002, 32'h0, 1'b0);
        @(negedge clk); #1;
        chk("bp_grant", 64'(cdb_grant), 64'b0001);
        chk("bp_ready1", {63'b0, fu_ready[1]}, 64'd0);
        step();
        @(negedge clk); #1;
        chk("bp_tag",  64'(cdb_rob_tag), 64'd21);
        chk("bp_data", 64'(cdb_data), 64'h1111_0001);
        step();
        fu_valid = '0;
        repeat (2) step();

        // Flush with buffers 0 and 3 full; FU2 valid during the flush is dropped
        fu_valid = 4'b1001;
        step();
        fu_valid = 4'b0100;
        set_fu(2, 5'd30, 32'h0000_0030, 32'h0, 1'b0);
        flush = 1'b1;
        @(negedge clk); #1;
        chk("fl_valid", {63'b0, cdb_valid}, 64'd0);
        chk("fl_ready", 64'(fu_ready), 64'd0);
        chk("fl_grant", 64'(cdb_grant), 64'd0);
        step();
        flush = 1'b0;
        fu_valid = '0;
        @(negedge clk); #1;
        chk("post_fl_valid", {63'b0, cdb_valid}, 64'd0);
        chk("post_fl_grant", 64'(cdb_grant), 64'd0);
        step();

        // Mispredict pass-through from FU3
        set_fu(3, 5'd12, 32'h0000_0003, 32'h0000_0400, 1'b1);
        fu_valid = 4'b1000;
        step();
        fu_valid = '0;
        @(negedge clk); #1;
        chk("mp_grant", 64'(cdb_grant), 64'b1000);
        chk("mp_misp",  {63'b0, cdb_mispredict}, 64'd1);
        chk("mp_tpc",   64'(cdb_target_pc), 64'h400);
        chk("mp_tag",   64'(cdb_rob_tag), 64'd12);
        step();
        fu_mispredict = '0;

        // Mixed request patterns, checked by the compare process; one flush
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++)
                set_fu(i, TL'(c * 4 + i), 32'h1000 * c + i, 32'h100 * i + c, 1'((c + i) % 3 == 0));
            fu_valid = masks[c];
            flush = (c == 7);
            step();
        end
        fu_valid = '0;
        flush = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
